// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO drain reader.
// Stats counter is compiled in only when FIFO_DRAIN_STATS_EN is defined.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam int unsigned SKID_DEPTH      = 2;
    localparam int unsigned FIFO_RD_LATENCY = 1;
    localparam int unsigned OCC_W           = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry in-order skid buffer that absorbs words returned by the FIFO read latency.
// Head entry is always the oldest word; occ counts valid entries 0..2.
module fifo_drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [OCC_W-1:0]  occ,
    output logic [DATA_W-1:0] head
);

    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == '0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                occ_d = occ_q + OCC_W'(1);
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - OCC_W'(1);
            end
            2'b11: begin
                // Occupancy unchanged: the new word lands behind whatever survives the pop.
                if (occ_q == OCC_W'(1)) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (occ_q == OCC_W'(SKID_DEPTH))));

    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        !(pop && (occ_q == '0)));

endmodule

// File: rtl/fifo_drain_reader.sv
// Read-side master for the team FIFO: issues pops, absorbs read latency in a skid buffer
// and presents words on a valid/ready stream. Define FIFO_DRAIN_STATS_EN to enable rd_count.
module fifo_drain_reader
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              rd_clk,
    input  logic              reset,
    input  logic              rd_enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_count
);

    state_e           state_q, state_d;
    logic             busy_q;
    logic             inflight_q;
    logic [OCC_W-1:0] occ;
    logic             pop;
    logic [OCC_W:0]   pending;

    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;

    // Words committed to the skid by the end of this cycle, i.e. next-cycle occupancy.
    assign pending = {1'b0, occ} + (OCC_W + 1)'(inflight_q) - (OCC_W + 1)'(pop);

    assign fifo_rd_en = !reset && rd_enable && !fifo_empty && (state_q == StRun)
                        && (pending < (OCC_W + 1)'(SKID_DEPTH));

    fifo_drain_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (rd_clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head      (m_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rd_enable) state_d = StRun;
            end
            StRun: begin
                if (!rd_enable) begin
                    state_d = ((occ != '0) || inflight_q) ? StDrain : StIdle;
                end
            end
            StDrain: begin
                // Leave as soon as the last word is handed over so busy drops right after it.
                if (rd_enable) begin
                    state_d = StRun;
                end else if (pending == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != StIdle);
            inflight_q <= fifo_rd_en;
        end
    end

    assign busy = busy_q;

`ifdef FIFO_DRAIN_STATS_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign rd_count = count_q;
`else
    assign rd_count = '0;
`endif

    a_no_pop_when_empty : assert property (@(posedge rd_clk) disable iff (reset)
        !(fifo_rd_en && fifo_empty));

    a_hold_when_stalled : assert property (@(posedge rd_clk) disable iff (reset)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Directed bench for fifo_drain_reader with a behavioural one-cycle-latency FIFO model.
`timescale 1ns/1ps
module tb_fifo_drain_reader;
    import fifo_drain_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
`ifdef FIFO_DRAIN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rd_enable = 1'b0;
    logic              force_empty = 1'b0;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              busy;
    logic [CNT_W-1:0]  rd_count;

    logic [7:0] mem [1024];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [7:0] got_mem [1024];
    int got_n  = 0;
    int n_rd   = 0;
    int n_viol = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_drain_reader #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .rd_clk     (clk),
        .reset      (reset),
        .rd_enable  (rd_enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .rd_count   (rd_count)
    );

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_data <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en) n_rd <= n_rd + 1;
        if (fifo_rd_en && fifo_empty) n_viol <= n_viol + 1;
        if (!reset && m_valid && m_ready) begin
            got_mem[got_n % 1024] <= m_data;
            got_n <= got_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr % 1024] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        rd_enable = 1'b0;
        m_ready = 1'b0;
        force_empty = 1'b0;
        tick();
        tick();
        wr_ptr = rd_ptr;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rd_count !== 8'd0) begin n_fail++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int k;
        int base_got;
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        base_got = got_n;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        rd_enable = 1'b1;
        m_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (fifo_rd_en !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_cmp++; if (k !== 1) begin n_fail++; $display("FAIL basic_first_issue: got cycle %0d want 1", k); end
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_n1: got %b want 0", m_valid); end
        @(negedge clk);
        n_cmp++; if ({m_valid, m_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL basic_word0: got %b/%h want 1/11", m_valid, m_data); end
        @(negedge clk);
        n_cmp++; if ({m_valid, m_data} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL basic_word1: got %b/%h want 1/22", m_valid, m_data); end
        @(negedge clk);
        n_cmp++; if ({m_valid, m_data} !== {1'b1, 8'h33}) begin n_fail++; $display("FAIL basic_word2: got %b/%h want 1/33", m_valid, m_data); end
        @(negedge clk);
        exp_cnt = STATS ? 8'd3 : 8'd0;
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after: got %b want 0", m_valid); end
        n_cmp++; if (rd_count !== exp_cnt) begin n_fail++; $display("FAIL basic_rd_count: got %0d want %0d", rd_count, exp_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_run: got %b want 1", busy); end
        tick();
        rd_enable = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy %b want 0", busy); end
        n_cmp++; if (got_n - base_got !== 3) begin n_fail++; $display("FAIL basic_count: got %0d words want 3", got_n - base_got); end
    endtask

    task automatic test_backpressure();
        int base_rd;
        int base_got;
        int bad;
        logic [7:0] exp_w;
        do_reset();
        base_rd = n_rd;
        base_got = got_n;
        for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
        rd_enable = 1'b1;
        m_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid && m_data !== 8'hA0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d bad cycles want 0", bad); end
        n_cmp++; if ({fifo_rd_en, m_valid, m_data} !== {1'b0, 1'b1, 8'hA0}) begin
            n_fail++; $display("FAIL bp_stalled_state: got rd_en %b valid %b data %h want 0/1/a0", fifo_rd_en, m_valid, m_data);
        end
        tick();
        n_cmp++; if (n_rd - base_rd !== 2) begin n_fail++; $display("FAIL bp_pops: got %0d want 2", n_rd - base_rd); end
        m_ready = 1'b1;
        repeat (14) tick();
        n_cmp++; if (got_n - base_got !== 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got_n - base_got); end
        for (int i = 0; i < 8; i++) begin
            exp_w = 8'hA0 + 8'(i);
            n_cmp++; if (got_mem[(base_got + i) % 1024] !== exp_w) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_mem[(base_got + i) % 1024], exp_w);
            end
        end
    endtask

    task automatic test_drain();
        int base_rd;
        int base_got;
        do_reset();
        base_got = got_n;
        push_word(8'h51); push_word(8'h52); push_word(8'h53); push_word(8'h54);
        rd_enable = 1'b1;
        m_ready = 1'b0;
        repeat (6) tick();
        base_rd = n_rd;
        rd_enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL drain_no_issue: got %b want 0", fifo_rd_en); end
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (dut.state_q !== StDrain) begin n_fail++; $display("FAIL drain_state: got %0d want %0d", dut.state_q, StDrain); end
        n_cmp++; if ({m_valid, m_data} !== {1'b1, 8'h51}) begin n_fail++; $display("FAIL drain_word0: got %b/%h want 1/51", m_valid, m_data); end
        tick();
        @(negedge clk);
        n_cmp++; if ({busy, m_valid, m_data} !== {1'b1, 1'b1, 8'h52}) begin
            n_fail++; $display("FAIL drain_word1: got busy %b valid %b data %h want 1/1/52", busy, m_valid, m_data);
        end
        tick();
        @(negedge clk);
        n_cmp++; if ({busy, m_valid} !== 2'b00) begin n_fail++; $display("FAIL drain_busy_fall: got busy %b valid %b want 0/0", busy, m_valid); end
        tick();
        n_cmp++; if (n_rd - base_rd !== 0) begin n_fail++; $display("FAIL drain_extra_pops: got %0d want 0", n_rd - base_rd); end
        n_cmp++; if (got_n - base_got !== 2) begin n_fail++; $display("FAIL drain_count: got %0d want 2", got_n - base_got); end
    endtask

    task automatic test_empty_toggle();
        int base_got;
        int base_viol;
        int bad;
        logic [15:0] pat;
        do_reset();
        base_got = got_n;
        base_viol = n_viol;
        for (int i = 0; i < 10; i++) push_word(8'hC0 + 8'(i));
        rd_enable = 1'b1;
        pat = 16'b1011_0010_1110_0101;
        for (int i = 0; i < 60; i++) begin
            force_empty = ~force_empty;
            m_ready = pat[i % 16];
            tick();
        end
        force_empty = 1'b0;
        m_ready = 1'b1;
        repeat (8) tick();
        n_cmp++; if (n_viol - base_viol !== 0) begin n_fail++; $display("FAIL toggle_pop_on_empty: got %0d want 0", n_viol - base_viol); end
        n_cmp++; if (got_n - base_got !== 10) begin n_fail++; $display("FAIL toggle_count: got %0d want 10", got_n - base_got); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (got_mem[(base_got + i) % 1024] !== 8'hC0 + 8'(i)) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL toggle_order: got %0d misplaced want 0", bad); end
    endtask

    task automatic test_reset_midflight();
        int k;
        int base_got;
        do_reset();
        base_got = got_n;
        for (int i = 0; i < 6; i++) push_word(8'hE0 + 8'(i));
        rd_enable = 1'b1;
        m_ready = 1'b0;
        k = 0;
        @(negedge clk);
        while (fifo_rd_en !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_cmp++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL mid_issue_timeout: got %b want 1", fifo_rd_en); end
        @(negedge clk);
        tick();
        reset = 1'b1;
        rd_enable = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        // Pre-reset condition: one word buffered, one still returning from the FIFO.
        n_cmp++; if ({dut.inflight_q, m_valid} !== 2'b11) begin
            n_fail++; $display("FAIL mid_precond: got inflight %b valid %b want 1/1", dut.inflight_q, m_valid);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", m_valid); end
        n_cmp++; if (rd_count !== 8'd0) begin n_fail++; $display("FAIL mid_rd_count: got %0d want 0", rd_count); end
        n_cmp++; if ({busy, fifo_rd_en} !== 2'b00) begin n_fail++; $display("FAIL mid_idle: got busy %b rd_en %b want 0/0", busy, fifo_rd_en); end
        repeat (4) tick();
        n_cmp++; if (got_n - base_got !== 0) begin n_fail++; $display("FAIL mid_delivered: got %0d want 0", got_n - base_got); end
    endtask

    task automatic test_stats();
        int base_got;
        int cnt;
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        base_got = got_n;
        for (int i = 0; i < 300; i++) push_word(8'(i));
        rd_enable = 1'b1;
        m_ready = 1'b1;
        cnt = 0;
        while ((got_n - base_got < 300) && cnt < 400) begin
            tick();
            cnt++;
        end
        n_cmp++; if (got_n - base_got !== 300) begin n_fail++; $display("FAIL stats_count: got %0d want 300", got_n - base_got); end
        n_cmp++; if (cnt !== 303) begin n_fail++; $display("FAIL stats_throughput: got %0d cycles want 303", cnt); end
        n_cmp++; if (got_mem[(base_got + 299) % 1024] !== 8'h2B) begin
            n_fail++; $display("FAIL stats_last_word: got %h want 2b", got_mem[(base_got + 299) % 1024]);
        end
        @(negedge clk);
        exp_cnt = STATS ? 8'd44 : 8'd0;
        n_cmp++; if (rd_count !== exp_cnt) begin n_fail++; $display("FAIL stats_rd_count: got %0d want %0d", rd_count, exp_cnt); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_drain();
        test_empty_toggle();
        test_reset_midflight();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
